// File: rtl/sccb_reg_writer.sv
// SCCB/I2C write master: START, four bytes with ACK slots, STOP, then a tr_end handshake.
// Optional NACK retry is enabled by defining I2C_NACK_RETRY_EN.
module sccb_reg_writer #(
    parameter int QDIV      = 600,
    parameter int RETRY_MAX = 3
) (
    input  logic        clk_24M,
    input  logic        camera_rstn,
    input  logic [31:0] i2c_data,
    input  logic        start,
    output logic        tr_end,
    output logic        ack,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);

    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [31:0]   shreg;
    logic          sda_low;
    logic          nack_s;
    logic          tick;

`ifdef I2C_NACK_RETRY_EN
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RW-1:0] retry_cnt;
    logic          retry_pend;
    logic [31:0]   data_lat;
`endif

    assign tick     = (qcnt == QW'(QDIV - 1));
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

    // Outputs are assigned for the phase being entered, so they change on the tick edge.
    always_ff @(posedge clk_24M) begin
        if (!camera_rstn) begin
            state    <= IDLE;
            qcnt     <= '0;
            phase    <= 2'd0;
            i2c_sclk <= 1'b1;
            sda_low  <= 1'b0;
            tr_end   <= 1'b0;
            ack      <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= i2c_data;
                        ack      <= 1'b0;
                        qcnt     <= '0;
                        phase    <= 2'd0;
                        byte_cnt <= 2'd0;
                        i2c_sclk <= 1'b1;
                        sda_low  <= 1'b0;
                        state    <= START;
`ifdef I2C_NACK_RETRY_EN
                        data_lat   <= i2c_data;
                        retry_cnt  <= '0;
                        retry_pend <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (!start) begin
                        tr_end <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    qcnt <= tick ? '0 : qcnt + 1'b1;
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (state)
                            START: begin
                                case (phase)
                                    2'd1: sda_low  <= 1'b1;
                                    2'd2: i2c_sclk <= 1'b0;
                                    2'd3: begin
                                        state   <= BIT;
                                        bit_cnt <= 3'd7;
                                        sda_low <= ~shreg[31];
                                    end
                                    default: ;
                                endcase
                            end
                            BIT: begin
                                case (phase)
                                    2'd1: i2c_sclk <= 1'b1;
                                    2'd3: begin
                                        i2c_sclk <= 1'b0;
                                        shreg    <= {shreg[30:0], 1'b0};
                                        if (bit_cnt == 3'd0) begin
                                            state   <= ACK;
                                            sda_low <= 1'b0;
                                        end else begin
                                            bit_cnt <= bit_cnt - 3'd1;
                                            sda_low <= ~shreg[30];
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            ACK: begin
                                case (phase)
                                    2'd1: i2c_sclk <= 1'b1;
                                    2'd2: nack_s   <= i2c_sdat;
                                    2'd3: begin
                                        i2c_sclk <= 1'b0;
                                        if (nack_s) begin
                                            state   <= STOP;
                                            sda_low <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
                                            if (retry_cnt < RW'(RETRY_MAX)) begin
                                                retry_cnt  <= retry_cnt + 1'b1;
                                                retry_pend <= 1'b1;
                                            end else begin
                                                ack <= 1'b1;
                                            end
`else
                                            ack <= 1'b1;
`endif
                                        end else if (byte_cnt == 2'd3) begin
                                            state   <= STOP;
                                            sda_low <= 1'b1;
                                        end else begin
                                            byte_cnt <= byte_cnt + 2'd1;
                                            state    <= BIT;
                                            bit_cnt  <= 3'd7;
                                            sda_low  <= ~shreg[31];
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            STOP: begin
                                case (phase)
                                    2'd0: i2c_sclk <= 1'b1;
                                    2'd1: sda_low  <= 1'b0;
                                    2'd3: begin
`ifdef I2C_NACK_RETRY_EN
                                        if (retry_pend) begin
                                            retry_pend <= 1'b0;
                                            shreg      <= data_lat;
                                            byte_cnt   <= 2'd0;
                                            state      <= START;
                                        end else
`endif
                                        begin
                                            state  <= DONE;
                                            tr_end <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
